// File: rtl/cmp_arbiter.sv
// Round-robin arbiter that shares one 33-bit subtract/compare datapath among NUM_REQ requesters.
// Each granted request produces a tagged, zero-extended flag in a one-entry response buffer.
module cmp_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   input  logic [NUM_REQ*32-1:0]  req_a_i,
   input  logic [NUM_REQ*32-1:0]  req_b_i,
   input  logic [NUM_REQ*2-1:0]   req_op_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [ID_W-1:0]        rsp_id_o,
   output logic [31:0]            rsp_result_o
);

   logic [31:0]     a_lane  [NUM_REQ];
   logic [31:0]     b_lane  [NUM_REQ];
   logic [1:0]      op_lane [NUM_REQ];

   logic [ID_W-1:0] ptr_reg;
   logic            rsp_valid_reg;
   logic [ID_W-1:0] rsp_id_reg;
   logic [31:0]     rsp_result_reg;

   logic            avail;
   logic            grant_any;
   logic [ID_W-1:0] grant_id;
   logic [NUM_REQ-1:0] grant;

   logic [31:0]     sel_a;
   logic [31:0]     sel_b;
   logic [1:0]      sel_op;
   logic [32:0]     diff;
   logic            borrow;
   logic            is_eq;
   logic            flag;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign a_lane[gi]  = req_a_i[gi*32 +: 32];
         assign b_lane[gi]  = req_b_i[gi*32 +: 32];
         assign op_lane[gi] = req_op_i[gi*2 +: 2];
      end
   endgenerate

   assign avail = !rsp_valid_reg || rsp_ready_i;

   // Search starts at ptr and wraps modulo NUM_REQ, so non-power-of-2 sizes work.
   always_comb begin
      int idx;
      grant     = '0;
      grant_any = 1'b0;
      grant_id  = '0;
      idx       = 0;
      if (avail && !rst_i) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_reg) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_any && req_valid_i[ID_W'(idx)]) begin
               grant_any           = 1'b1;
               grant_id            = ID_W'(idx);
               grant[ID_W'(idx)]   = 1'b1;
            end
         end
      end
   end

   assign req_ready_o = grant;

   assign sel_a  = a_lane[grant_id];
   assign sel_b  = b_lane[grant_id];
   assign sel_op = op_lane[grant_id];
   assign diff   = {1'b0, sel_a} - {1'b0, sel_b};
   assign borrow = diff[32];
   assign is_eq  = (diff[31:0] == 32'd0);

   always_comb begin
      flag = 1'b0;
      case (sel_op)
         2'b00:   flag = (sel_a[31] ^ sel_b[31]) ? sel_a[31] : borrow;
         2'b01:   flag = borrow;
         2'b10:   flag = is_eq;
         default: flag = !is_eq;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_valid_reg  <= 1'b0;
         rsp_id_reg     <= '0;
         rsp_result_reg <= '0;
         ptr_reg        <= '0;
      end else if (grant_any) begin
         rsp_valid_reg  <= 1'b1;
         rsp_id_reg     <= grant_id;
         rsp_result_reg <= {31'b0, flag};
         ptr_reg        <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end else if (rsp_ready_i) begin
         rsp_valid_reg  <= 1'b0;
      end
   end

   assign rsp_valid_o  = rsp_valid_reg;
   assign rsp_id_o     = rsp_id_reg;
   assign rsp_result_o = rsp_result_reg;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: a 4-requester instance for most steps and a
// 3-requester instance for the non-power-of-2 pointer wrap.
module tb_cmp_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;

   logic [3:0]   valid4 = '0;
   logic [3:0]   ready4;
   logic [127:0] a4 = '0;
   logic [127:0] b4 = '0;
   logic [7:0]   op4 = '0;
   logic         rsp_valid4;
   logic         rsp_ready4 = 1'b1;
   logic [1:0]   rsp_id4;
   logic [31:0]  rsp_result4;

   logic [2:0]   valid3 = '0;
   logic [2:0]   ready3;
   logic [95:0]  a3 = '0;
   logic [95:0]  b3 = '0;
   logic [5:0]   op3 = '0;
   logic         rsp_valid3;
   logic         rsp_ready3 = 1'b1;
   logic [1:0]   rsp_id3;
   logic [31:0]  rsp_result3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cmp_arbiter #(.NUM_REQ(4)) u0 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(valid4), .req_ready_o(ready4),
      .req_a_i(a4), .req_b_i(b4), .req_op_i(op4),
      .rsp_valid_o(rsp_valid4), .rsp_ready_i(rsp_ready4),
      .rsp_id_o(rsp_id4), .rsp_result_o(rsp_result4)
   );

   cmp_arbiter #(.NUM_REQ(3)) u3 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(valid3), .req_ready_o(ready3),
      .req_a_i(a3), .req_b_i(b3), .req_op_i(op3),
      .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3),
      .rsp_id_o(rsp_id3), .rsp_result_o(rsp_result3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane4(input int k, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      a4[k*32 +: 32] = a;
      b4[k*32 +: 32] = b;
      op4[k*2 +: 2]  = op;
   endtask

   // One isolated request on lane k of the 4-way instance, checked through to its response.
   task automatic issue(input string tag, input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] exp_res);
      set_lane4(k, a, b, op);
      valid4 = 4'b0001 << k;
      #1;
      chk({tag, "_ready"}, 32'(ready4), 32'(4'b0001 << k));
      step();
      valid4 = '0;
      chk({tag, "_valid"}, 32'(rsp_valid4), 32'd1);
      chk({tag, "_id"}, 32'(rsp_id4), 32'(k));
      chk({tag, "_result"}, rsp_result4, exp_res);
      $display("txn %s lane=%0d a=%h b=%h op=%0d result=%h", tag, k, a, b, op, rsp_result4);
   endtask

   initial begin
      // Reset: outputs clear and no grant while reset is held, even with valid requests.
      rst = 1'b1;
      valid4 = 4'b1111;
      step();
      step();
      chk("rst_ready", 32'(ready4), 32'd0);
      chk("rst_valid", 32'(rsp_valid4), 32'd0);
      chk("rst_id", 32'(rsp_id4), 32'd0);
      chk("rst_result", rsp_result4, 32'd0);
      valid4 = '0;
      rst = 1'b0;
      step();

      // Single-lane operations
      issue("slt_m1_1",   0, 32'hFFFFFFFF, 32'h00000001, 2'b00, 32'd1);
      issue("sltu_m1_1",  0, 32'hFFFFFFFF, 32'h00000001, 2'b01, 32'd0);
      issue("slt_min",    2, 32'h80000000, 32'h7FFFFFFF, 2'b00, 32'd1);
      issue("sltu_min",   2, 32'h80000000, 32'h7FFFFFFF, 2'b01, 32'd0);
      issue("eq_5",       2, 32'h00000005, 32'h00000005, 2'b10, 32'd1);
      issue("ne_5",       2, 32'h00000005, 32'h00000005, 2'b11, 32'd0);
      issue("slt_0_min",  2, 32'h00000000, 32'h80000000, 2'b00, 32'd0);
      issue("sltu_0_min", 2, 32'h00000000, 32'h80000000, 2'b01, 32'd1);
      step();
      chk("drain_idle_valid", 32'(rsp_valid4), 32'd0);

      // Round-robin from a fresh pointer with all lanes valid: no bubbles.
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_lane4(0, 32'd5, 32'd5, 2'b10);
      set_lane4(1, 32'd5, 32'd5, 2'b11);
      set_lane4(2, 32'd1, 32'd2, 2'b01);
      set_lane4(3, 32'd3, 32'd2, 2'b00);
      valid4 = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         logic [31:0] exp_res;
         #1;
         chk("rr_ready", 32'(ready4), 32'(4'b0001 << (i % 4)));
         step();
         exp_res = ((i % 4) == 0 || (i % 4) == 2) ? 32'd1 : 32'd0;
         chk("rr_valid", 32'(rsp_valid4), 32'd1);
         chk("rr_id", 32'(rsp_id4), 32'(i % 4));
         chk("rr_result", rsp_result4, exp_res);
         $display("txn rr cycle=%0d id=%0d result=%h", i, rsp_id4, rsp_result4);
      end
      valid4 = '0;

      // Backpressure on lane 1: held output, no grants, then same-cycle drain and grant.
      set_lane4(1, 32'd1, 32'd2, 2'b01);
      valid4 = 4'b0010;
      #1;
      chk("bp_first_ready", 32'(ready4), 32'b0010);
      step();
      rsp_ready4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_hold_ready", 32'(ready4), 32'd0);
         chk("bp_hold_valid", 32'(rsp_valid4), 32'd1);
         chk("bp_hold_id", 32'(rsp_id4), 32'd1);
         chk("bp_hold_result", rsp_result4, 32'd1);
         $display("txn bp hold cycle=%0d id=%0d result=%h", i, rsp_id4, rsp_result4);
         step();
      end
      rsp_ready4 = 1'b1;
      #1;
      chk("bp_release_ready", 32'(ready4), 32'b0010);
      step();
      valid4 = '0;
      chk("bp_release_valid", 32'(rsp_valid4), 32'd1);
      chk("bp_release_id", 32'(rsp_id4), 32'd1);
      step();
      chk("bp_empty_valid", 32'(rsp_valid4), 32'd0);

      // Reset while a response is pending and all lanes request (pointer sits at 2).
      valid4 = 4'b1111;
      rsp_ready4 = 1'b0;
      #1;
      chk("mid_pre_ready", 32'(ready4), 32'b0100);
      step();
      chk("mid_pre_id", 32'(rsp_id4), 32'd2);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(ready4), 32'd0);
      step();
      chk("mid_rst_valid", 32'(rsp_valid4), 32'd0);
      rst = 1'b0;
      rsp_ready4 = 1'b1;
      #1;
      chk("mid_after_ready", 32'(ready4), 32'b0001);
      step();
      chk("mid_after_id", 32'(rsp_id4), 32'd0);
      $display("txn mid_reset first_id=%0d", rsp_id4);
      valid4 = '0;

      // Three-requester instance: pointer wraps from 2 back to 0.
      a3[0 +: 32]  = 32'd0;  b3[0 +: 32]  = 32'd0;  op3[0 +: 2] = 2'b10;
      a3[64 +: 32] = 32'd2;  b3[64 +: 32] = 32'd1;  op3[4 +: 2] = 2'b01;
      valid3 = 3'b101;
      #1;
      chk("n3_first_ready", 32'(ready3), 32'b001);
      step();
      chk("n3_first_id", 32'(rsp_id3), 32'd0);
      chk("n3_first_result", rsp_result3, 32'd1);
      #1;
      chk("n3_second_ready", 32'(ready3), 32'b100);
      step();
      chk("n3_second_id", 32'(rsp_id3), 32'd2);
      chk("n3_second_result", rsp_result3, 32'd0);
      #1;
      chk("n3_wrap_ready", 32'(ready3), 32'b001);
      step();
      chk("n3_wrap_id", 32'(rsp_id3), 32'd0);
      $display("txn n3 wrap id=%0d result=%h", rsp_id3, rsp_result3);
      valid3 = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
